// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampled SPI receiver that turns LSB-first frames on cs/sclk/mosi into parallel words on a valid/ready output
module spi_slave_rx #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              sclk,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RECV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
    logic                   cs_d, sclk_d, mosi_d;
    logic                   cs_fall, cs_rise, sclk_fall;
    logic [1:0]             state;
    logic [CW-1:0]          bitcnt;
    logic [DATA_W-1:0]      shreg;
    logic                   extra;
    logic                   done, good;

    assign done = state == DONE;
    assign good = bitcnt == CW'(DATA_W) && !extra;
    assign busy = state != IDLE;

    // Synchronizer chains plus one delay flop per input; all reset low so cs held low through reset never looks like a fall
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_d      <= 1'b0;
            sclk_d    <= 1'b0;
            mosi_d    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_d      <= cs_sync[SYNC_STAGES-1];
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            mosi_d    <= mosi_sync[SYNC_STAGES-1];
        end
    end

    // Registered edge pulses; mosi_d is aligned with the sample that produced sclk_fall
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_fall   <= 1'b0;
            cs_rise   <= 1'b0;
            sclk_fall <= 1'b0;
        end else begin
            cs_fall   <= cs_d & ~cs_sync[SYNC_STAGES-1];
            cs_rise   <= ~cs_d & cs_sync[SYNC_STAGES-1];
            sclk_fall <= sclk_d & ~sclk_sync[SYNC_STAGES-1];
        end
    end

    // Frame FSM: a bit landing together with cs rise is still captured before DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            bitcnt <= '0;
            shreg  <= '0;
            extra  <= 1'b0;
        end else if (state == IDLE) begin
            if (cs_fall) begin
                shreg  <= '0;
                bitcnt <= '0;
                extra  <= 1'b0;
                state  <= RECV;
            end
        end else if (state == RECV) begin
            if (sclk_fall && bitcnt < CW'(DATA_W)) begin
                shreg[bitcnt] <= mosi_d;
                bitcnt        <= bitcnt + CW'(1);
            end else if (sclk_fall) begin
                extra <= 1'b1;
            end
            if (cs_rise)
                state <= DONE;
        end else begin
            state <= IDLE;
        end
    end

    // Output slot: a good frame loads only if the slot is empty or draining now; otherwise it is dropped as overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= done & ~good;
            overrun   <= done & good & dout_valid & ~dout_ready;
            if (done && good && (!dout_valid || dout_ready)) begin
                dout       <= shreg;
                dout_valid <= 1'b1;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

Receive-side SPI stage that consumes the serial stream produced by the team's 12-bit SPI master (`cs`, `sclk`, `mosi`) and turns each frame back into a parallel word. All three SPI wires are oversampled in the system `clk` domain. They are synchronized, edge-detected and shifted in LSB first. Completed frames are presented on a valid/ready output with error and overrun reporting.

## Interface
- `DATA_W`, 12: bits per frame, also the `dout` width.
- `SYNC_STAGES`, 2: synchronizer flops per SPI input; minimum 2.

Ports:
- `clk`  input  1  system clock; the only clock in the block.
- `rst`  input  1  synchronous, active-high reset.
- `cs`  input  1  SPI chip select, active low; asynchronous to `clk`.
- `sclk`  input  1  SPI serial clock; asynchronous, treated as data.
- `mosi`  input  1  SPI serial data; changes after `sclk` rising edges.
- `dout`  output  DATA_W  received word; valid only while `dout_valid`=1.
- `dout_valid`  output  1  word available.
- `dout_ready`  input  1  consumer accepts the word when high together with `dout_valid`.
- `busy`  output  1  high while a frame is being received (state RECV or DONE).
- `frame_err`  output  1  one-cycle pulse when a frame ends with a bit count other than DATA_W.
- `overrun`  output  1  one-cycle pulse when a good frame is dropped because the output is still occupied.

## Operation
- **Input synchronization**
  - Each input passes through SPI_SYNC_STAGES flops, then one delay flop for edge detection.
  - Reset values: `cs` chain = 0, `sclk` chain = 0, `mosi` chain = 0.
  - Because `cs` resets low, a `cs` held low through reset produces no falling edge. The block arms only after it has seen `cs` high.
- **Edge definitions (synchronized signals)**
  - `cs_fall` = high→low, `cs_rise` = low→high.
  - `sclk_fall` = high→low.
  - Bits are sampled on `sclk_fall`, because the master drives `mosi` on `sclk` rising edges.
- **FSM states: IDLE, RECV, DONE**
  - **IDLE**
    - On `cs_fall`: clear the shift register and `bitcnt`, clear the `extra` flag, go to RECV.
    - All other edges are ignored.
  - **RECV**
    - On `sclk_fall` with `bitcnt` < DATA_W: `shreg[bitcnt]` ← `mosi`, `bitcnt` += 1.
    - On `sclk_fall` with `bitcnt` == DATA_W: set `extra`; `bitcnt` saturates.
    - On `cs_rise`: go to DONE.
    - If `sclk_fall` and `cs_rise` occur in the same cycle, the bit is sampled first, then the FSM goes to DONE.
  - **DONE (exactly 1 cycle, always returns to IDLE)**
    - Good frame (`bitcnt` == DATA_W and `extra` = 0):
      - If the output slot is empty, or is being drained this cycle (`dout_valid` & `dout_ready`): `dout` ← `shreg`, `dout_valid` ← 1.
      - Otherwise: pulse `overrun`; the new word is discarded and the held word is kept.
    - Bad frame (any other count, or `extra` = 1): pulse `frame_err`; the output slot is untouched.
- **Output slot**
  - `dout_valid` stays high until a cycle with `dout_ready` = 1.
  - `dout` is stable while `dout_valid` is high.
  - `dout` keeps its last value after the handshake.
  - `dout_ready` with `dout_valid` = 0 has no effect.
- **Reset mid-frame:** the partial frame is discarded and the FSM returns to IDLE. No `frame_err` is raised for the aborted frame.

## Timing
- Reset values: `dout` = 0, `dout_valid` = 0, `busy` = 0, `frame_err` = 0, `overrun` = 0; state = IDLE; `bitcnt` = 0.
- Input latency: a pin transition is visible as an edge pulse SYNC_STAGES + 1 `clk` edges after the first `clk` edge that samples the new level.
- Frame-end latency: DONE is entered on the next edge after `cs_rise`, and `dout_valid` rises on the edge after that. With the default SYNC_STAGES, this is 5 `clk` edges after `cs` rise is first sampled.
- Minimum `sclk` high and low times: 3 `clk` cycles each. The master's 11-cycle half period meets this.
- Minimum `cs` high time between frames: 3 `clk` cycles.
- Throughput: one word per frame. `frame_err` and `overrun` are single-cycle and never assert together.

## Test plan
- **Single frame, LSB first:** send 12'hA5C with `dout_ready` = 1. Required: exactly one cycle of `dout_valid` with `dout` = 12'hA5C; `frame_err` = 0.
- **Backpressure and overrun:** hold `dout_ready` = 0, send 12'h123 then 12'h456. Required:
  - `dout` = 12'h123 held.
  - One `overrun` pulse at the end of the second frame.
  - After `dout_ready` is raised, a single handshake of 12'h123.
- **Short and long frames:** raise `cs` after 11 bits; then send 13 bits. Required: a `frame_err` pulse for each frame, `dout_valid` stays 0.
- **Drain in the same cycle:** `dout_ready` pulses in the same cycle the second frame's DONE occurs. Required: 12'h123 is consumed, then 12'h456 is loaded with `dout_valid` = 1 and no `overrun`.
- **Reset mid-frame:** assert `rst` after 5 bits with `cs` still low, then release. Required:
  - All outputs 0 and no `frame_err`.
  - No frame starts until `cs` goes high then low.
  - The next full frame 12'hFFF is received correctly.
- **Coincident edges:** the final `sclk` fall and the `cs` rise land in the same synchronized cycle. Required: the 12th bit is captured and the word is correct.
